mems_scan_sequencer: RTL and testbench
======================================

# mems_scan_sequencer

Upstream feeder for the 24-bit MEMS DAC SPI master. After reset it sends one DAC reference-enable word, then generates a raster scan: X is a triangle wave, Y steps at each X turnaround. Each scan point is issued as two DAC command words, X on channel A and then Y on channel B with update-all, paced by a point-rate divider. The block drives the SPI master's `data_in`/`start` and consumes its `busy`/`new_data`.

## Interface
- `POINT_DIV`, 2000: clocks per scan point (tick period); legal range ≥ 64.
- `X_MIN`, 16'h1000: X lower bound.
- `X_MAX`, 16'hF000: X upper bound; `X_MAX > X_MIN`.
- `X_STEP`, 16'h0100: X increment; nonzero.
- `Y_MIN`, 16'h1000: Y lower bound.
- `Y_MAX`, 16'hF000: Y upper bound; `Y_MAX ≥ Y_MIN`.
- `Y_STEP`, 16'h0400: Y increment per line; nonzero.

Ports:
- `clk` in 1: single clock domain.
- `rst` in 1: synchronous, active-low reset (asserted when 0, sampled on posedge `clk`).
- `en` in 1: scan enable.
- `spi_busy` in 1: SPI master `busy`.
- `spi_done` in 1: SPI master `new_data`, a one-cycle end-of-word pulse.
- `spi_data` out 24: word to SPI master `data_in`.
- `spi_start` out 1: one-cycle start pulse to SPI master.
- `frame_wrap` out 1: one-cycle pulse when Y wraps to `Y_MIN`.
- `overrun` out 1: sticky flag, set when a tick is lost.
- `scan_busy` out 1: high when the state is not IDLE.

## Operation
Word formats are `{2'b00, cmd[2:0], addr[2:0], data[15:0]}`:
- INIT: cmd 3'b111, addr 0, data 16'h0001, i.e. 24'h380001.
- X: cmd 3'b000, addr 3'b000, data x, i.e. {8'h00, x}.
- Y: cmd 3'b010, addr 3'b001, data y, i.e. {8'h11, y}.

States and transitions:
- INIT_SEND: on entry from reset, assert `spi_start` with INIT when `spi_busy`=0, then go to INIT_WAIT.
- INIT_WAIT: go to IDLE on `spi_done`.
- IDLE: if `tick_pend` and `en`, go to X_SEND.
- X_SEND → X_WAIT: `spi_start` with the X word.
- X_WAIT: go to Y_SEND on `spi_done`.
- Y_SEND → Y_WAIT: `spi_start` with the Y word.
- Y_WAIT: on `spi_done`, update coordinates and return to IDLE.
- Every *_SEND state waits while `spi_busy`=1.
- `spi_done` is ignored in IDLE and in *_SEND.
- INIT is sent regardless of `en`.

Tick generation:
- Counter 0..`POINT_DIV`-1 runs while `en`=1. `tick` fires when the counter wraps.
- `tick` sets `tick_pend`. Launching X_SEND clears it.
- A tick while `tick_pend` is already set asserts `overrun`. The tick is dropped, not queued.
- `en`=0: counter and `tick_pend` are held at 0. A point already in flight completes both words.

Coordinate update on Y_WAIT `spi_done`, using 17-bit sums:
- Direction up: if `x+X_STEP ≥ X_MAX`, set x=`X_MAX`, dir=down, line_end; else x+=`X_STEP`.
- Direction down: if `x ≤ X_MIN+X_STEP`, set x=`X_MIN`, dir=up, line_end; else x-=`X_STEP`.
- line_end: if `y+Y_STEP > Y_MAX`, set y=`Y_MIN` and pulse `frame_wrap` in the same cycle; else y+=`Y_STEP`.

Initial scan point after reset: x=`X_MIN`, y=`Y_MIN`, dir=up.

## Timing
Reset values:
- `spi_start`=0, `spi_data`=0, `frame_wrap`=0, `overrun`=0, `scan_busy`=1 (INIT_SEND).
- counter=0, `tick_pend`=0.

Handshake:
- `spi_start` is registered and high for exactly one cycle per word. It is never asserted while `spi_busy`=1 or while a word is outstanding.
- `spi_data` is loaded in the same cycle `spi_start` rises. It is held stable until the cycle after the matching `spi_done`, because the SPI master samples `data_in` throughout its pre-transfer wait.

Latencies:
- `tick_pend` and `en` in IDLE → `spi_start` (X) on the next cycle.
- X `spi_done` → Y `spi_start` after 1 cycle (X_WAIT→Y_SEND→pulse).
- Y `spi_done` → updated x/y registered on the next edge.

Boundary cases:
- `spi_done` and `tick` in the same cycle: both take effect (pend set, state advances).
- Reset mid-transfer: all state reinitialises and INIT is resent. The SPI master shares the same reset.
- Step overshoot clamps to the bound exactly. X therefore always visits `X_MIN` and `X_MAX`.

## Test plan
- **Init:** release `rst` with the SPI model idle → the first `spi_start` carries 24'h380001. No further starts until `spi_done`, even with `en`=0.
- **First point:** `en`=1, `POINT_DIV`=64 → X word 24'h001000 then Y word 24'h111000. The Y start comes 1 cycle after X done, and `spi_data` is stable through each transfer.
- **Turnaround and clamp:** `X_MIN`=0, `X_MAX`=0x0250, `X_STEP`=0x0100 → X sequence 0000, 0100, 0200, 0250, 0150, 0050, 0000, 0100. Y increments when x=0250 and when x=0000.
- **Frame wrap:** `Y_MIN`=0, `Y_MAX`=0x0800, `Y_STEP`=0x0400 → Y goes 0000, 0400, 0800, 0000 across line ends. `frame_wrap` pulses once, exactly at the 0800→0000 update.
- **Overrun:** SPI model stretches `busy` beyond 2×`POINT_DIV` → `overrun` rises on the second tick and stays high until reset. No extra `spi_start` is issued.
- **Enable drop and reset:** drop `en` between X done and Y start → the Y word is still sent, then no further starts. Assert `rst` mid-Y transfer → outputs return to reset values and INIT is resent after release.

Source files
------------

// File: rtl/mems_scan_sequencer.sv
// Raster-scan command sequencer feeding a 24-bit MEMS DAC SPI master.
// After reset it sends the DAC reference-enable word. After that, on every
// point tick it sends one X word (channel A) and one Y word (channel B,
// update-all). X traces a triangle wave. Y advances by one step at each
// X turnaround.
//
// Ports:
//   clk         single clock domain
//   rst         synchronous active-low reset
//   en          scan enable (gates the point-rate divider)
//   spi_busy    SPI master busy
//   spi_done    SPI master end-of-word pulse (new_data)
//   spi_data    24-bit word presented to the SPI master data_in
//   spi_start   one-cycle start pulse to the SPI master
//   frame_wrap  one-cycle pulse when Y wraps back to Y_MIN
//   overrun     sticky flag, set when a point tick is dropped
//   scan_busy   high whenever the sequencer is not IDLE
module mems_scan_sequencer #(
    parameter int unsigned POINT_DIV = 2000,
    parameter logic [15:0] X_MIN     = 16'h1000,
    parameter logic [15:0] X_MAX     = 16'hF000,
    parameter logic [15:0] X_STEP    = 16'h0100,
    parameter logic [15:0] Y_MIN     = 16'h1000,
    parameter logic [15:0] Y_MAX     = 16'hF000,
    parameter logic [15:0] Y_STEP    = 16'h0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        spi_busy,
    input  logic        spi_done,
    output logic [23:0] spi_data,
    output logic        spi_start,
    output logic        frame_wrap,
    output logic        overrun,
    output logic        scan_busy
);

    localparam int unsigned CNT_W = $clog2(POINT_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POINT_DIV - 1);
    localparam logic [23:0] INIT_WORD = 24'h380001;

    typedef enum logic [2:0] {
        INIT_SEND,
        INIT_WAIT,
        IDLE,
        X_SEND,
        X_WAIT,
        Y_SEND,
        Y_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              tick_pend;
    logic [15:0]       x, x_nxt;
    logic [15:0]       y, y_nxt;
    logic              dir_up, dir_up_nxt;
    logic              start_nxt;
    logic [23:0]       data_nxt;
    logic              wrap_nxt;
    logic              line_end;
    logic              tick_c;
    logic              launch_c;
    logic [16:0]       x_up_sum;
    logic [16:0]       x_dn_lim;
    logic [16:0]       y_up_sum;

    assign tick_c   = en && (cnt == CNT_LAST);
    assign launch_c = (state == IDLE) && tick_pend && en;
    assign x_up_sum = {1'b0, x} + {1'b0, X_STEP};
    assign x_dn_lim = {1'b0, X_MIN} + {1'b0, X_STEP};
    assign y_up_sum = {1'b0, y} + {1'b0, Y_STEP};

    // Point-rate divider, pending tick and sticky overrun
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            tick_pend <= 1'b0;
            overrun   <= 1'b0;
        end else if (!en) begin
            cnt       <= '0;
            tick_pend <= 1'b0;
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            // A tick arriving in the launch cycle re-arms pend, so it is not lost
            if (tick_c)
                tick_pend <= 1'b1;
            else if (launch_c)
                tick_pend <= 1'b0;
            if (tick_c && tick_pend && !launch_c)
                overrun <= 1'b1;
        end
    end

    // State, coordinate and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= INIT_SEND;
            x          <= X_MIN;
            y          <= Y_MIN;
            dir_up     <= 1'b1;
            spi_start  <= 1'b0;
            spi_data   <= '0;
            frame_wrap <= 1'b0;
            scan_busy  <= 1'b1;
        end else begin
            state      <= state_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            dir_up     <= dir_up_nxt;
            spi_start  <= start_nxt;
            spi_data   <= data_nxt;
            frame_wrap <= wrap_nxt;
            scan_busy  <= (state_nxt != IDLE);
        end
    end

    // Next-state, next-output and coordinate update
    always_comb begin
        state_nxt  = state;
        start_nxt  = 1'b0;
        data_nxt   = spi_data;
        x_nxt      = x;
        y_nxt      = y;
        dir_up_nxt = dir_up;
        wrap_nxt   = 1'b0;
        line_end   = 1'b0;

        case (state)
            INIT_SEND: begin
                if (!spi_busy) begin
                    start_nxt = 1'b1;
                    data_nxt  = INIT_WORD;
                    state_nxt = INIT_WAIT;
                end
            end
            INIT_WAIT: begin
                if (spi_done)
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (tick_pend && en)
                    state_nxt = X_SEND;
            end
            X_SEND: begin
                if (!spi_busy) begin
                    start_nxt = 1'b1;
                    data_nxt  = {8'h00, x};
                    state_nxt = X_WAIT;
                end
            end
            X_WAIT: begin
                if (spi_done)
                    state_nxt = Y_SEND;
            end
            Y_SEND: begin
                if (!spi_busy) begin
                    start_nxt = 1'b1;
                    data_nxt  = {8'h11, y};
                    state_nxt = Y_WAIT;
                end
            end
            Y_WAIT: begin
                if (spi_done) begin
                    state_nxt = IDLE;
                    // Overshoot clamps to the bound so both X extremes are visited
                    if (dir_up) begin
                        if (x_up_sum >= {1'b0, X_MAX}) begin
                            x_nxt      = X_MAX;
                            dir_up_nxt = 1'b0;
                            line_end   = 1'b1;
                        end else begin
                            x_nxt = x_up_sum[15:0];
                        end
                    end else begin
                        if ({1'b0, x} <= x_dn_lim) begin
                            x_nxt      = X_MIN;
                            dir_up_nxt = 1'b1;
                            line_end   = 1'b1;
                        end else begin
                            x_nxt = x - X_STEP;
                        end
                    end
                    if (line_end) begin
                        if (y_up_sum > {1'b0, Y_MAX}) begin
                            y_nxt    = Y_MIN;
                            wrap_nxt = 1'b1;
                        end else begin
                            y_nxt = y_up_sum[15:0];
                        end
                    end
                end
            end
            default: state_nxt = INIT_SEND;
        endcase
    end

endmodule

// File: tb/tb_mems_scan_sequencer.sv
// Directed bench for mems_scan_sequencer with a small SPI master model.
module tb_mems_scan_sequencer;

    localparam int unsigned P = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        spi_busy;
    logic        spi_done;
    logic [23:0] spi_data;
    logic        spi_start;
    logic        frame_wrap;
    logic        overrun;
    logic        scan_busy;

    mems_scan_sequencer #(
        .POINT_DIV (P),
        .X_MIN     (16'h0000),
        .X_MAX     (16'h0250),
        .X_STEP    (16'h0100),
        .Y_MIN     (16'h0000),
        .Y_MAX     (16'h0800),
        .Y_STEP    (16'h0400)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spi_busy   (spi_busy),
        .spi_done   (spi_done),
        .spi_data   (spi_data),
        .spi_start  (spi_start),
        .frame_wrap (frame_wrap),
        .overrun    (overrun),
        .scan_busy  (scan_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SPI master model state
    logic [23:0] words[$];
    int          y_lat[$];
    logic [23:0] cur_word = '0;
    int          xfer_len = 10;
    int          viol     = 0;
    int          stab_err = 0;
    int unsigned last_done = 0;
    int          wrap_cnt = 0;
    int          wrap_at  = -1;

    // SPI master model: captures words, holds busy, then pulses done
    initial begin
        bit aborted;
        spi_busy = 1'b0;
        spi_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst && spi_start) begin
                cur_word = spi_data;
                words.push_back(spi_data);
                if (spi_data[23:16] == 8'h11)
                    y_lat.push_back(int'(cyc - last_done));
                aborted  = 1'b0;
                spi_busy = 1'b1;
                for (int i = 0; i < xfer_len; i++) begin
                    @(posedge clk); #1;
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (spi_start) viol++;
                    if (spi_data !== cur_word) stab_err++;
                end
                spi_busy = 1'b0;
                if (!aborted) begin
                    spi_done = 1'b1;
                    @(posedge clk); #1;
                    spi_done  = 1'b0;
                    last_done = cyc;
                    if (rst && spi_data !== cur_word) stab_err++;
                    if (rst && spi_start) viol++;
                end
            end
        end
    end

    // frame_wrap monitor: records how many words had been issued at the pulse
    initial begin
        forever begin
            @(posedge clk); #1;
            if (frame_wrap) begin
                wrap_cnt++;
                wrap_at = words.size();
            end
        end
    end

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (words.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("wait_words", 32'(words.size() >= n), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"},  32'(spi_start),  32'd0);
        check({tag, "_data"},   32'(spi_data),   32'd0);
        check({tag, "_wrap"},   32'(frame_wrap), 32'd0);
        check({tag, "_ovr"},    32'(overrun),    32'd0);
        check({tag, "_busy"},   32'(scan_busy),  32'd1);
    endtask

    logic [15:0] xe[11] = '{16'h0000, 16'h0100, 16'h0200, 16'h0250, 16'h0150, 16'h0050,
                            16'h0000, 16'h0100, 16'h0200, 16'h0250, 16'h0150};
    logic [15:0] ye[11] = '{16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0400, 16'h0400,
                            16'h0800, 16'h0800, 16'h0800, 16'h0000, 16'h0000};

    initial begin
        int n;
        int lat_min;
        int lat_max;
        bit hit;

        rst = 1'b0;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");

        // Init word goes out regardless of en, and nothing else follows
        rst = 1'b1;
        wait_words(1, 20);
        check("init_word", 32'(words[0]), 32'h380001);
        repeat (300) @(posedge clk);
        #1;
        check("init_only", 32'(words.size()), 32'd1);
        check("idle_busy", 32'(scan_busy), 32'd0);

        // Raster scan: triangle X with clamp, Y steps at turnarounds and wraps
        en = 1'b1;
        wait_words(23, 3000);
        for (int p = 0; p < 11; p++) begin
            check($sformatf("x_word%0d", p), 32'(words[1 + 2 * p]), 32'({8'h00, xe[p]}));
            check($sformatf("y_word%0d", p), 32'(words[2 + 2 * p]), 32'({8'h11, ye[p]}));
        end
        check("wrap_count", 32'(wrap_cnt), 32'd1);
        check("wrap_at", 32'(wrap_at), 32'd19);
        check("no_overrun", 32'(overrun), 32'd0);

        // Enable drop between X done and Y start: Y still sent, then silence
        hit = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #2;
            if (spi_done && cur_word[23:16] == 8'h00) begin
                hit = 1'b1;
                break;
            end
        end
        check("drop_x_done_seen", 32'(hit), 32'd1);
        en = 1'b0;
        n = words.size();
        wait_words(n + 1, 100);
        check("drop_y_sent", 32'(words[n][23:16]), 32'h11);
        repeat (400) @(posedge clk);
        #1;
        check("drop_no_more", 32'(words.size()), 32'(n + 1));

        // Overrun: long transfers drop ticks; flag is sticky
        xfer_len = 200;
        en = 1'b1;
        repeat (800) @(posedge clk);
        #1;
        check("overrun_set", 32'(overrun), 32'd1);
        xfer_len = 10;
        repeat (300) @(posedge clk);
        #1;
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset during a Y transfer, then INIT is resent
        hit = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (spi_busy && cur_word[23:16] == 8'h11) begin
                hit = 1'b1;
                break;
            end
        end
        check("midy_seen", 32'(hit), 32'd1);
        rst = 1'b0;
        en  = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst1");
        repeat (2) @(posedge clk);
        #1;
        n = words.size();
        rst = 1'b1;
        wait_words(n + 1, 20);
        check("reinit_word", 32'(words[n]), 32'h380001);
        repeat (50) @(posedge clk);
        #1;
        check("reinit_only", 32'(words.size()), 32'(n + 1));

        // Handshake properties across the whole run
        lat_min = 1000;
        lat_max = -1;
        foreach (y_lat[i]) begin
            if (y_lat[i] < lat_min) lat_min = y_lat[i];
            if (y_lat[i] > lat_max) lat_max = y_lat[i];
        end
        check("y_lat_min", 32'(lat_min), 32'd1);
        check("y_lat_max", 32'(lat_max), 32'd1);
        check("start_while_busy", 32'(viol), 32'd0);
        check("data_stable", 32'(stab_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
